// File: rtl/sa_tile_feeder.sv
// Feeds one tile command into the 4x4 systolic array: clear, k aligned A/B words, then FLUSH_CYC zero beats.
// done arrives k+3+FLUSH_CYC cycles after acceptance; commands are held off (cmd_ready=0) until back in IDLE.
module sa_tile_feeder #(
  parameter int ADDR_W    = 12,
  parameter int K_W       = 16,
  parameter int FLUSH_CYC = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [K_W-1:0]    cmd_k,
  input  logic [ADDR_W-1:0] cmd_a_base,
  input  logic [ADDR_W-1:0] cmd_b_base,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_rdata,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_rdata,
  output logic              sa_start,
  output logic              sa_vld,
  output logic [31:0]       sa_a_bus,
  output logic [31:0]       sa_b_bus,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [K_W-1:0]      r_k;
  logic [K_W-1:0]      r_cnt;
  logic [K_W-1:0]      w_cnt_nxt;
  logic [ADDR_W-1:0]   r_a_base;
  logic [ADDR_W-1:0]   r_b_base;
  logic                r_rd_q;
  logic                w_rd_en;
  logic                w_flush_zero;
  logic                w_accept;
  logic                w_cnt_last;
  logic                w_flush_last;

  assign w_accept     = cmd_valid & cmd_ready;
  // r_k is nonzero whenever STREAM is entered, so k-1 cannot underflow.
  assign w_cnt_last   = (r_cnt == (r_k - K_W'(1)));
  assign w_flush_last = (r_cnt == K_W'(FLUSH_CYC));

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    cmd_ready    = 1'b0;
    sa_start     = 1'b0;
    w_rd_en      = 1'b0;
    w_flush_zero = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        w_cnt_nxt = '0;
        if (cmd_valid) w_state_nxt = S_CLR;
      end
      S_CLR: begin
        sa_start    = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = (r_k != '0) ? S_STREAM : S_DONE;
      end
      S_STREAM: begin
        w_rd_en = 1'b1;
        if (w_cnt_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_FLUSH;
        end else begin
          w_cnt_nxt = r_cnt + K_W'(1);
        end
      end
      S_FLUSH: begin
        // Beat 0 carries the final read word; beats 1..FLUSH_CYC are zero.
        w_flush_zero = (r_cnt != '0);
        if (w_flush_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + K_W'(1);
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_k      <= '0;
      r_a_base <= '0;
      r_b_base <= '0;
      r_rd_q   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rd_q  <= w_rd_en;
      if (w_accept) begin
        r_k      <= cmd_k;
        r_a_base <= cmd_a_base;
        r_b_base <= cmd_b_base;
      end
    end
  end

  assign a_rd_en  = w_rd_en;
  assign b_rd_en  = w_rd_en;
  assign a_addr   = r_a_base + ADDR_W'(r_cnt);
  assign b_addr   = r_b_base + ADDR_W'(r_cnt);
  assign sa_vld   = r_rd_q | w_flush_zero;
  assign sa_a_bus = r_rd_q ? a_rdata : '0;
  assign sa_b_bus = r_rd_q ? b_rdata : '0;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_sa_tile_feeder.sv
// Scoreboarded bench for sa_tile_feeder with a behavioural buffer and 4x4 accumulate model.
module tb_sa_tile_feeder;
  localparam int ADDR_W = 12;
  localparam int K_W    = 16;
  localparam int FC     = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [K_W-1:0]    cmd_k;
  logic [ADDR_W-1:0] cmd_a_base;
  logic [ADDR_W-1:0] cmd_b_base;
  logic              a_rd_en;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_rdata;
  logic              b_rd_en;
  logic [ADDR_W-1:0] b_addr;
  logic [31:0]       b_rdata;
  logic              sa_start;
  logic              sa_vld;
  logic [31:0]       sa_a_bus;
  logic [31:0]       sa_b_bus;
  logic              busy;
  logic              done;

  sa_tile_feeder #(.ADDR_W(ADDR_W), .K_W(K_W), .FLUSH_CYC(FC)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_k(cmd_k), .cmd_a_base(cmd_a_base), .cmd_b_base(cmd_b_base),
    .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rdata(a_rdata),
    .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rdata(b_rdata),
    .sa_start(sa_start), .sa_vld(sa_vld), .sa_a_bus(sa_a_bus), .sa_b_bus(sa_b_bus),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                done_off;
    int                vld_n;
    logic [15:0][31:0] c;
  } tile_t;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          acc_cyc = -100;
  int          last_done_cyc = -100;
  int          vld_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] amem [0:4095];
  logic [31:0] bmem [0:4095];
  logic [31:0] cm [16];
  logic [63:0] bus_q [$];
  logic [23:0] addr_q [$];
  tile_t       tile_q [$];
  logic [63:0] m_bus;
  logic [23:0] m_addr;
  tile_t       m_t;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read buffers: data appears the cycle after the enable.
  always @(posedge clk) begin
    if (a_rd_en) a_rdata <= amem[a_addr];
    if (b_rd_en) b_rdata <= bmem[b_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_vs_busy", {63'd0, cmd_ready}, {63'd0, !busy});
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (sa_start) begin
        chk("start_cycle", cyc - acc_cyc, 1);
        chk("start_no_vld", {63'd0, sa_vld}, 0);
        for (int i = 0; i < 16; i++) cm[i] = '0;
        vld_cnt = 0;
      end
      if (a_rd_en || b_rd_en) begin
        if (addr_q.size() == 0) chk("read_unexpected", {a_rd_en, b_rd_en}, 0);
        else begin
          m_addr = addr_q.pop_front();
          chk("rd_addr", {a_rd_en, b_rd_en, a_addr, b_addr}, {2'b11, m_addr});
        end
      end
      if (sa_vld) begin
        vld_cnt++;
        if (bus_q.size() == 0) chk("vld_unexpected", {63'd0, sa_vld}, 0);
        else begin
          m_bus = bus_q.pop_front();
          chk("sa_bus", {sa_a_bus, sa_b_bus}, m_bus);
        end
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            cm[i*4+j] = cm[i*4+j] + 32'(sa_a_bus[31-8*i -: 8]) * 32'(sa_b_bus[31-8*j -: 8]);
      end else begin
        chk("bus_zero_idle", {sa_a_bus, sa_b_bus}, 0);
      end
      if (done) begin
        if (tile_q.size() == 0) chk("done_unexpected", {63'd0, done}, 0);
        else begin
          m_t = tile_q.pop_front();
          chk("done_cycle", cyc - acc_cyc, m_t.done_off);
          chk("vld_count", vld_cnt, m_t.vld_n);
          for (int n = 0; n < 16; n++) chk($sformatf("c%0d%0d", n / 4, n % 4), cm[n], m_t.c[n]);
        end
        last_done_cyc = cyc;
        done_cnt++;
      end
    end
  end

  task automatic issue(input int k, input logic [11:0] ab, input logic [11:0] bb, input tile_t t);
    int n;
    logic [11:0] aa;
    logic [11:0] ba;
    for (int i = 0; i < k; i++) begin
      aa = ab + 12'(i);
      ba = bb + 12'(i);
      addr_q.push_back({aa, ba});
      bus_q.push_back({amem[aa], bmem[ba]});
    end
    if (k != 0) for (int i = 0; i < FC; i++) bus_q.push_back(64'd0);
    tile_q.push_back(t);
    cmd_k      = K_W'(k);
    cmd_a_base = ab;
    cmd_b_base = bb;
    cmd_valid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", {63'd0, cmd_ready}, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("done_seen", done_cnt, target);
    #1;
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_ctrl"}, {cmd_ready, a_rd_en, b_rd_en, sa_start, sa_vld, busy, done}, 7'b1000000);
    chk({nm, "_addr"}, {a_addr, b_addr}, 0);
    chk({nm, "_bus"}, {sa_a_bus, sa_b_bus}, 0);
  endtask

  function automatic tile_t mk(input int done_off, input int vld_n, input int kind);
    tile_t t;
    t.done_off = done_off;
    t.vld_n    = vld_n;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        case (kind)
          0: t.c[i*4+j] = 32'(4 * i + j + 1);                       // identity: C = B
          1: t.c[i*4+j] = 32'((i + 1) * (j + 5));                    // outer product
          3: t.c[i*4+j] = (i < 2) ? 32'd4 : 32'd3;                   // wrap tile
          default: t.c[i*4+j] = 32'd0;
        endcase
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_k      = '0;
    cmd_a_base = '0;
    cmd_b_base = '0;
    for (int i = 0; i < 4096; i++) begin
      amem[i] = '0;
      bmem[i] = '0;
    end
    amem[0] = 32'h01000000; amem[1] = 32'h00010000;
    amem[2] = 32'h00000100; amem[3] = 32'h00000001;
    bmem[12'h010] = 32'h01020304; bmem[12'h011] = 32'h05060708;
    bmem[12'h012] = 32'h090A0B0C; bmem[12'h013] = 32'h0D0E0F10;
    amem[12'h200] = 32'h01020304; bmem[12'h300] = 32'h05060708;
    amem[12'hFFE] = 32'h01010101; amem[12'hFFF] = 32'h02020202;
    for (int i = 0; i < 4; i++) bmem[12'h100 + i] = 32'h01010101;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    issue(4, 12'h000, 12'h010, mk(13, 10, 0));
    wait_done(1);
    issue(1, 12'h200, 12'h300, mk(10, 7, 1));
    wait_done(2);
    issue(0, 12'h020, 12'h030, mk(2, 0, 2));
    wait_done(3);
    issue(4, 12'hFFE, 12'h100, mk(13, 10, 3));
    wait_done(4);

    // Second command raised mid-stream and held through done.
    issue(4, 12'h000, 12'h010, mk(13, 10, 0));
    repeat (3) @(posedge clk);
    #1;
    issue(1, 12'h200, 12'h300, mk(10, 7, 1));
    chk("held_cmd_accept", acc_cyc, last_done_cyc + 1);
    wait_done(6);

    // Reset during STREAM of a k=8 tile.
    issue(8, 12'h400, 12'h500, mk(17, 14, 2));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    addr_q.delete();
    bus_q.delete();
    tile_q.delete();
    @(negedge clk);
    check_reset("midrst");
    @(negedge clk);
    check_reset("midrst_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {cmd_ready, busy}, 2'b10);
    @(posedge clk);
    #1;
    issue(4, 12'h000, 12'h010, mk(13, 10, 0));
    wait_done(7);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
